// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared mesh constants, FSM state types and node-to-grid mapping
package noc_pkg;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int GRID_W      = 6;
    localparam int GRID_OFFSET = 7;
    localparam int MESH_DIM    = 4;
    localparam int NODE_W      = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ACK,
        RX_DROP
    } rx_state_t;

    // Mesh nodes sit inside a bordered GRID_W-wide grid, so rows advance by GRID_W.
    function automatic logic [ADDR_W-1:0] node_to_grid(input logic [NODE_W-1:0] node);
        return ADDR_W'(GRID_OFFSET + (int'(node) / MESH_DIM) * GRID_W + (int'(node) % MESH_DIM));
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - synchronous FIFO with wrap-bit pointers and full/empty flags
module noc_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/node_nic_32b.sv
// rtl/node_nic_32b.sv - mesh endpoint NIC: TX queue to router, RX queue to local sink
module node_nic_32b
    import noc_pkg::*;
#(
    parameter int ID       = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_req_valid,
    output logic        tx_req_ready,
    input  logic [3:0]  tx_req_dest,
    input  logic [31:0] tx_req_data,
    output logic [7:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        from_out_ack,
    input  logic [7:0]  in_addr,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        to_in_ack,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_addr,
    output logic [31:0] rx_data,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic        rx_misroute
);

    localparam int                PKT_W   = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] MY_GRID = node_to_grid(NODE_W'(ID));

    tx_state_t         tx_state, tx_next;
    rx_state_t         rx_state, rx_next;
    logic              tx_push, tx_pop, tx_done, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [PKT_W-1:0]  tx_head, rx_head;

    assign tx_req_ready = !tx_full;
    assign tx_push      = tx_req_valid && tx_req_ready;
    assign rx_valid     = !rx_empty;
    assign rx_pop       = rx_valid && rx_ready;
    assign {rx_addr, rx_data} = rx_head;

    noc_fifo #(.WIDTH(PKT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (tx_push),
        .wdata ({node_to_grid(tx_req_dest), tx_req_data}),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    noc_fifo #(.WIDTH(PKT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (rx_push),
        .wdata ({in_addr, in_data}),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        tx_done = 1'b0;
        case (tx_state)
            TX_IDLE: if (!tx_empty) begin
                tx_pop  = 1'b1;
                tx_next = TX_SEND;
            end
            TX_SEND: if (from_out_ack) begin
                tx_done = 1'b1;
                tx_next = TX_GAP;
            end
            TX_GAP:  tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state  <= TX_IDLE;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            tx_count  <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                out_valid            <= 1'b1;
                {out_addr, out_data} <= tx_head;
            end else if (tx_done) begin
                out_valid <= 1'b0;
                tx_count  <= tx_count + 16'd1;
            end
        end
    end

    // DROP holds off re-capture until the router withdraws the packet it just had acked.
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        case (rx_state)
            RX_IDLE: if (in_valid && !rx_full) begin
                rx_push = 1'b1;
                rx_next = RX_ACK;
            end
            RX_ACK:  rx_next = RX_DROP;
            RX_DROP: if (!in_valid) rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state    <= RX_IDLE;
            to_in_ack   <= 1'b0;
            rx_misroute <= 1'b0;
            rx_count    <= '0;
        end else begin
            rx_state    <= rx_next;
            to_in_ack   <= rx_push;
            rx_misroute <= rx_push && (in_addr != MY_GRID);
            if (rx_pop) rx_count <= rx_count + 16'd1;
        end
    end

endmodule
